// File: rtl/ahb_ctrl_io_pkg.sv
// Shared constants and types for the AHB-Lite game-control I/O slave:
// register offsets, STATUS bit positions and the pulse-engine state type.
package ahb_ctrl_io_pkg;

  localparam logic [31:0] OFF_LEVEL     = 32'h0000_0000;
  localparam logic [31:0] OFF_MODE      = 32'h0000_0004;
  localparam logic [31:0] OFF_TRIG      = 32'h0000_0008;
  localparam logic [31:0] OFF_PULSE_LEN = 32'h0000_000C;
  localparam logic [31:0] OFF_STATUS    = 32'h0000_0010;
  localparam logic [31:0] OFF_IRQ_EN    = 32'h0000_0014;
  localparam logic [31:0] OFF_ID        = 32'h0000_0018;

  localparam int ST_OVF     = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_CNT_CLR = 2;

  localparam logic [31:0] DEFAULT_ID   = 32'h4354_0100;
  localparam logic [15:0] TRIG_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } pulse_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == TRIG_CNT_MAX) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/ahb_ctrl_io_pulse.sv
// Single-channel one-shot pulse engine: a start loads the length counter and
// busy stays high for exactly len cycles; abort drops back to idle silently.
module ctrl_pulse_ch
  import ahb_ctrl_io_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [PW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ovf_o
);

  localparam logic [PW-1:0] CNT_ONE = PW'(32'd1);

  pulse_state_e  state_q;
  logic [PW-1:0] cnt_q;
  logic          busy_q;
  logic          last_s;

  // A counter of 0 can only come from a bad load; treat it as the last cycle.
  assign last_s = (cnt_q <= CNT_ONE);

  // Pulse state machine with registered busy output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PS_IDLE;
      cnt_q   <= {PW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        PS_IDLE: begin
          if (start_i && !abort_i) begin
            state_q <= PS_ACTIVE;
            cnt_q   <= len_i;
            busy_q  <= 1'b1;
          end else begin
            state_q <= PS_IDLE;
            busy_q  <= 1'b0;
          end
        end
        PS_ACTIVE: begin
          if (abort_i || last_s) begin
            state_q <= PS_IDLE;
            cnt_q   <= {PW{1'b0}};
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= PS_IDLE;
          cnt_q   <= {PW{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = (state_q == PS_ACTIVE) & ~abort_i & last_s;
  assign ovf_o  = (state_q == PS_ACTIVE) & start_i;

endmodule

// File: rtl/ahb_ctrl_io.sv
// AHB-Lite slave driving NUM_CH game-control lines in level or pulse mode,
// with sticky OVF/DONE status, a saturating trigger counter and an IRQ.
module ahb_ctrl_io
  import ahb_ctrl_io_pkg::*;
#(
  parameter int          NUM_CH = 8,
  parameter int          PW     = 16,
  parameter int          ADDR_W = 8,
  parameter logic [31:0] ID_VAL = DEFAULT_ID
) (
  input  logic              AHB_HCLK,
  input  logic              AHB_HRESETn,
  input  logic              AHB_HSEL,
  input  logic [31:0]       AHB_HADDR,
  input  logic [1:0]        AHB_HTRANS,
  input  logic              AHB_HWRITE,
  input  logic [2:0]        AHB_HSIZE,
  input  logic [31:0]       AHB_HWDATA,
  output logic [31:0]       AHB_HRDATA,
  output logic              AHB_HREADY,
  output logic [1:0]        AHB_HRESP,
  output logic [NUM_CH-1:0] ch_out,
  output logic              irq
);

  localparam logic [PW-1:0] PLEN_ONE = PW'(32'd1);

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              valid_q;

  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [PW-1:0]     plen_q, plen_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [1:0]        irqen_q, irqen_d;

  logic [31:0]       off_s;
  logic              wr_s, rd_s, trig_wr_s, status_wr_s, tcnt_clr_s, accept_s;
  logic [15:0]       tcnt_base_s;
  logic [NUM_CH-1:0] start_s, busy_s, done_s, ovf_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  assign unused_s = ^{AHB_HSIZE, AHB_HADDR, AHB_HWDATA};

  // Address-phase capture; no wait states so every cycle is a sample point
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      addr_q  <= {ADDR_W{1'b0}};
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= AHB_HADDR[ADDR_W-1:0];
      write_q <= AHB_HWRITE;
      valid_q <= AHB_HSEL & AHB_HTRANS[1];
    end
  end

  assign off_s       = 32'(addr_q);
  assign wr_s        = valid_q & write_q;
  assign rd_s        = valid_q & ~write_q;
  assign trig_wr_s   = wr_s & (off_s == OFF_TRIG);
  assign status_wr_s = wr_s & (off_s == OFF_STATUS);

  assign start_s  = {NUM_CH{trig_wr_s}} & AHB_HWDATA[NUM_CH-1:0] & mode_q;
  assign accept_s = |(start_s & ~busy_s);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ctrl_pulse_ch #(.PW(PW)) u_pulse (
      .clk_i   (AHB_HCLK),
      .rst_ni  (AHB_HRESETn),
      .start_i (start_s[g]),
      .abort_i (~mode_q[g]),
      .len_i   (plen_q),
      .busy_o  (busy_s[g]),
      .done_o  (done_s[g]),
      .ovf_o   (ovf_s[g])
    );
  end

  // Software-writable register next-state
  always_comb begin
    level_d = level_q;
    mode_d  = mode_q;
    plen_d  = plen_q;
    irqen_d = irqen_q;
    if (wr_s) begin
      case (off_s)
        OFF_LEVEL:     level_d = AHB_HWDATA[NUM_CH-1:0];
        OFF_MODE:      mode_d  = AHB_HWDATA[NUM_CH-1:0];
        OFF_PULSE_LEN: plen_d  = (AHB_HWDATA[PW-1:0] == {PW{1'b0}}) ? PLEN_ONE
                                                                   : AHB_HWDATA[PW-1:0];
        OFF_IRQ_EN:    irqen_d = AHB_HWDATA[1:0];
        default:       level_d = level_q;
      endcase
    end else begin
      level_d = level_q;
    end
  end

  // Hardware set beats a same-cycle W1C
  assign ovf_d  = (|ovf_s)  | (ovf_q  & ~(status_wr_s & AHB_HWDATA[ST_OVF]));
  assign done_d = (|done_s) | (done_q & ~(status_wr_s & AHB_HWDATA[ST_DONE]));

  assign tcnt_clr_s  = status_wr_s & AHB_HWDATA[ST_CNT_CLR];
  assign tcnt_base_s = tcnt_clr_s ? 16'd0 : tcnt_q;
  assign tcnt_d      = accept_s ? sat_inc16(tcnt_base_s) : tcnt_base_s;

  // Register file state
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      level_q <= {NUM_CH{1'b0}};
      mode_q  <= {NUM_CH{1'b0}};
      plen_q  <= PLEN_ONE;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      tcnt_q  <= 16'd0;
      irqen_q <= 2'b00;
    end else begin
      level_q <= level_d;
      mode_q  <= mode_d;
      plen_q  <= plen_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      tcnt_q  <= tcnt_d;
      irqen_q <= irqen_d;
    end
  end

  // Read mux over the registered data-phase address
  always_comb begin
    rdata_s = 32'd0;
    if (rd_s) begin
      case (off_s)
        OFF_LEVEL:     rdata_s = 32'(level_q);
        OFF_MODE:      rdata_s = 32'(mode_q);
        OFF_TRIG:      rdata_s = 32'(busy_s);
        OFF_PULSE_LEN: rdata_s = 32'(plen_q);
        OFF_STATUS:    rdata_s = {tcnt_q, 14'd0, done_q, ovf_q};
        OFF_IRQ_EN:    rdata_s = {30'd0, irqen_q};
        OFF_ID:        rdata_s = ID_VAL;
        default:       rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign AHB_HRDATA = rdata_s;
  assign AHB_HREADY = 1'b1;
  assign AHB_HRESP  = 2'b00;

  // Pulse-mode channels show the engine, so reset drops them asynchronously
  assign ch_out = (mode_q & busy_s) | (~mode_q & level_q);
  assign irq    = |({done_q, ovf_q} & irqen_q);

endmodule

// File: tb/tb_ahb_ctrl_io.sv
// Directed, scoreboarded bench for ahb_ctrl_io: reads push expected data on
// the address phase and are checked when their data phase comes round.
module tb_ahb_ctrl_io;

  localparam logic [31:0] A_LEVEL  = 32'h00;
  localparam logic [31:0] A_MODE   = 32'h04;
  localparam logic [31:0] A_TRIG   = 32'h08;
  localparam logic [31:0] A_PLEN   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_IRQEN  = 32'h14;
  localparam logic [31:0] A_ID     = 32'h18;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [7:0]  ch_out;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int pc;

  logic        rd_pend;
  logic [31:0] wd_pend;
  logic [31:0] sb_q[$];
  logic [31:0] sba_q[$];

  always #5 hclk = ~hclk;

  ahb_ctrl_io dut (
    .AHB_HCLK    (hclk),
    .AHB_HRESETn (hresetn),
    .AHB_HSEL    (hsel),
    .AHB_HADDR   (haddr),
    .AHB_HTRANS  (htrans),
    .AHB_HWRITE  (hwrite),
    .AHB_HSIZE   (hsize),
    .AHB_HWDATA  (hwdata),
    .AHB_HRDATA  (hrdata),
    .AHB_HREADY  (hready),
    .AHB_HRESP   (hresp),
    .ch_out      (ch_out),
    .irq         (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bus cycle: finish the previous data phase and issue a new address phase.
  task automatic step(input logic act, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] e_v;
    logic [31:0] ea_v;
    if (rd_pend) begin
      e_v  = sb_q.pop_front();
      ea_v = sba_q.pop_front();
      chk($sformatf("rd@%h", ea_v), hrdata, e_v);
    end
    hwdata  = wd_pend;
    hsel    = act;
    htrans  = act ? 2'b10 : 2'b00;
    hwrite  = w;
    haddr   = a;
    rd_pend = act & ~w;
    wd_pend = (act & w) ? d : 32'd0;
    if (act && !w) begin
      sb_q.push_back(d);
      sba_q.push_back(a);
    end
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv);
    step(1'b1, 1'b0, a, expv);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    haddr   = 32'd0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'b010;
    hwdata  = 32'd0;
    rd_pend = 1'b0;
    wd_pend = 32'd0;
    repeat (2) @(negedge hclk);
    chk("rst_ch_out", {24'd0, ch_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Reset values through the bus
    rd(A_ID, 32'h4354_0100);
    rd(A_LEVEL, 32'd0);
    rd(A_MODE, 32'd0);
    rd(A_TRIG, 32'd0);
    rd(A_PLEN, 32'd1);
    rd(A_STATUS, 32'd0);
    rd(A_IRQEN, 32'd0);
    idle();
    chk("idle_ch_out", {24'd0, ch_out}, 32'd0);

    // Level mode, back-to-back write then read
    wr(A_LEVEL, 32'h0000_00A5);
    rd(A_LEVEL, 32'h0000_00A5);
    chk("level_out", {24'd0, ch_out}, 32'h0000_00A5);
    idle();

    // Pulse of 4 on channel 0
    wr(A_MODE, 32'd1);
    wr(A_PLEN, 32'd4);
    wr(A_TRIG, 32'd1);
    idle();
    chk("pulse_start", {31'd0, ch_out[0]}, 32'd1);
    pc = 1;
    repeat (8) begin
      idle();
      pc = pc + int'(ch_out[0]);
    end
    chk("pulse_len4", 32'(pc), 32'd4);
    chk("level_bits", {25'd0, ch_out[7:1]}, 32'h52);
    rd(A_STATUS, 32'h0001_0002);
    wr(A_IRQEN, 32'd2);
    idle();
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'd2);
    idle();
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(A_STATUS, 32'h0001_0000);

    // Retrigger while active: no extension, OVF set, count unchanged
    wr(A_TRIG, 32'd1);
    pc = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) wr(A_TRIG, 32'd1);
      else idle();
      pc = pc + int'(ch_out[0]);
    end
    chk("retrig_len4", 32'(pc), 32'd4);
    rd(A_STATUS, 32'h0002_0003);
    wr(A_STATUS, 32'd3);

    // PULSE_LEN of 0 becomes 1
    wr(A_PLEN, 32'd0);
    rd(A_PLEN, 32'd1);
    wr(A_TRIG, 32'd1);
    pc = 0;
    repeat (5) begin
      idle();
      pc = pc + int'(ch_out[0]);
    end
    chk("pulse_len1", 32'(pc), 32'd1);
    rd(A_STATUS, 32'h0003_0002);
    wr(A_STATUS, 32'd3);

    // Two channels, abort channel 1 mid-pulse
    wr(A_MODE, 32'd3);
    wr(A_PLEN, 32'd10);
    wr(A_TRIG, 32'd3);
    pc = 0;
    idle();
    pc = pc + int'(ch_out[0]);
    chk("ch1_start", {31'd0, ch_out[1]}, 32'd1);
    rd(A_TRIG, 32'd3);
    pc = pc + int'(ch_out[0]);
    wr(A_MODE, 32'd1);
    pc = pc + int'(ch_out[0]);
    chk("ch1_still", {31'd0, ch_out[1]}, 32'd1);
    idle();
    pc = pc + int'(ch_out[0]);
    chk("ch1_abort", {31'd0, ch_out[1]}, 32'd0);
    rd(A_STATUS, 32'h0004_0000);
    pc = pc + int'(ch_out[0]);
    repeat (10) begin
      idle();
      pc = pc + int'(ch_out[0]);
    end
    chk("ch0_len10", 32'(pc), 32'd10);
    chk("ch1_low", {31'd0, ch_out[1]}, 32'd0);
    rd(A_STATUS, 32'h0004_0002);

    // Trigger on a level-mode channel is ignored; then clear TRIG_CNT
    wr(A_TRIG, 32'd2);
    idle();
    chk("mode0_trig", {31'd0, ch_out[1]}, 32'd0);
    rd(A_STATUS, 32'h0004_0002);
    wr(A_STATUS, 32'd4);
    rd(A_STATUS, 32'h0000_0002);

    // Asynchronous reset mid-pulse
    wr(A_TRIG, 32'd1);
    idle();
    chk("pre_reset", {31'd0, ch_out[0]}, 32'd1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("async_ch_out", {24'd0, ch_out}, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_hrdata", hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    rd(A_LEVEL, 32'd0);
    rd(A_MODE, 32'd0);
    rd(A_PLEN, 32'd1);
    rd(A_STATUS, 32'd0);
    rd(A_IRQEN, 32'd0);
    rd(32'h40, 32'd0);
    chk("hresp_okay", {30'd0, hresp}, 32'd0);
    chk("hready", {31'd0, hready}, 32'd1);
    idle();
    chk("post_rst_ch_out", {24'd0, ch_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
